array_drain: RTL and testbench
==============================

// Module: array_drain
// PURPOSE
//  Output-side collector for the systolic array. Column c of down_out carries row r's result one cycle
//  after column c-1 (diagonal skew). This block de-skews the columns into aligned rows and buffers them
//  in a small FIFO. It hands each row to the writeback consumer over a valid/ready handshake.
//  The array cannot stall, so the block flags any row dropped while the buffer is full.
// PARAMETERS
//  COLUMN_NUMBER  256  columns in the array; also the width of one output row, in 8-bit elements
//  FIFO_DEPTH     4    aligned rows buffered; must be >= 2
// PORTS
//  clk        in   1                  single clock; all state updates on posedge
//  reset      in   1                  synchronous, active-high
//  in_valid   in   1                  down_out[0] carries a valid row element this cycle
//  down_in    in   8 x COLUMN_NUMBER  array outputs, skewed: column c valid at in_valid time + c
//  out_valid  out  1                  row_out holds an aligned row
//  out_ready  in   1                  consumer accepts the row when out_valid && out_ready
//  row_out    out  8 x COLUMN_NUMBER  aligned row; element c is from column c
//  overflow   out  1                  sticky: a row was dropped because the FIFO was full
//  occupancy  out  $clog2(FIFO_DEPTH+1)  rows currently held in the FIFO
// BEHAVIOUR
//  Reset values: out_valid=0, row_out=0, overflow=0, occupancy=0. All delay-line data and valid bits clear.
//  Valid skew: internal vld[c] = in_valid delayed c cycles. Element c is captured when vld[c] is high.
//  Data skew: column c passes through (COLUMN_NUMBER-1-c) registers, so all columns of one row align.
//  Push: the aligned row pushes into the FIFO in the cycle vld[COLUMN_NUMBER-1] is high.
//  Latency: in_valid high in cycle t, FIFO empty -> out_valid=1 in cycle t+COLUMN_NUMBER, with that row.
//  FIFO is show-ahead: the head row drives row_out whenever occupancy>0.
//  out_valid = (occupancy != 0). row_out is held stable while out_valid && !out_ready.
//  Pop happens on out_valid && out_ready. Rows pop in push order; no reordering.
//  Push and pop in the same cycle: both take effect and occupancy is unchanged. This applies when full.
//  Push while full with no pop: the incoming row is discarded, FIFO contents are untouched,
//    and overflow sets to 1 the next cycle. overflow clears only on reset.
//  Back-to-back in_valid (one row every cycle) is supported at full rate if the consumer holds out_ready=1.
//  Gaps in in_valid leave gaps in pushes. down_in is ignored when its derived vld bit is low.
//  Reset asserted mid-operation: in-flight skewed rows and FIFO contents are lost. No partial row ever
//    appears after reset.
//  Pointers wrap modulo FIFO_DEPTH. FIFO_DEPTH need not be a power of 2.
// CONFIGURATION
//  DRAIN_DROP_CNT_EN defined: adds output port drop_count [15:0], reset 0.
//    It increments once per discarded row and saturates at 16'hFFFF. overflow behaviour is unchanged.
//  Not defined: the port and counter do not exist; only the sticky overflow bit reports drops.
// STRUCTURE
//  tpu_pkg: typedef logic [7:0] elem_t. Function clog2-based OCC_W width helper.
//    Row type is a parameterised unpacked array elem_t [0:COLUMN_NUMBER-1].
//  Sub-module drain_fifo (#(WIDTH_ELEMS, DEPTH)): show-ahead FIFO of rows.
//    Ports: push, pop, din, dout, full, empty, count.
//  Top level holds the per-column delay lines (generate loop), the vld shift chain,
//    the overflow logic and the optional counter.
// TESTING (run with COLUMN_NUMBER=4, FIFO_DEPTH=2 unless noted)
//  1 Single row: in_valid pulse at t with skewed col c = 8'h10+c. Expect out_valid at t+4 with
//    row_out={10,11,12,13}; with out_ready=1, out_valid drops at t+5.
//  2 Streaming: 8 consecutive rows (row r, col c = 16*r+c) with out_ready=1. Expect 8 rows in order
//    on 8 consecutive cycles and overflow=0.
//  3 Backpressure: out_ready=0 and 3 rows pushed. Rows 0 and 1 are held and row 2 is dropped.
//    Expect overflow=1 and occupancy=2; drop_count=1 if DRAIN_DROP_CNT_EN.
//    Releasing out_ready yields rows 0 then 1.
//  4 Full with simultaneous pop: FIFO full, out_ready=1 in the same cycle a new row pushes.
//    Expect no drop, occupancy stays 2, output order intact.
//  5 Reset mid-flight: reset 2 cycles after in_valid. Expect out_valid=0 for all of the next
//    COLUMN_NUMBER+2 cycles, and overflow=0.
//  6 Gap pattern: in_valid 1,0,1,1,0,1 with out_ready=1. Expect exactly 4 rows with correct data
//    and no phantom rows from the ignored down_in values.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared element type and width helpers for the systolic-array output path.
package tpu_pkg;

  typedef logic [7:0] elem_t;

  // Bits needed to hold a count of 0..depth inclusive.
  function automatic int unsigned occ_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/drain_fifo.sv
// Show-ahead FIFO of whole rows; the head row is held in a register so dout is flop-driven.
module drain_fifo
  import tpu_pkg::*;
#(
  parameter int unsigned WIDTH_ELEMS = 256,
  parameter int unsigned DEPTH       = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  elem_t                      din   [WIDTH_ELEMS],
  output elem_t                      dout  [WIDTH_ELEMS],
  output logic                       full,
  output logic                       empty,
  output logic [occ_w(DEPTH)-1:0]    count
);

  localparam int unsigned CNT_W = occ_w(DEPTH);
  localparam int unsigned PTR_W = ptr_w(DEPTH);

  elem_t              r_mem  [DEPTH][WIDTH_ELEMS];
  elem_t              r_dout [WIDTH_ELEMS];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_full;
  logic               r_empty;

  logic [PTR_W-1:0]   w_wr_nxt;
  logic [PTR_W-1:0]   w_rd_nxt;
  logic [CNT_W-1:0]   w_count_nxt;
  logic               w_do_push;
  logic               w_do_pop;
  logic               w_bypass;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A push while full is accepted only when the head leaves in the same cycle.
  always_comb begin
    w_do_pop    = pop && !r_empty;
    w_do_push   = push && (!r_full || w_do_pop);
    w_rd_nxt    = w_do_pop  ? ptr_inc(r_rd_ptr) : r_rd_ptr;
    w_wr_nxt    = w_do_push ? ptr_inc(r_wr_ptr) : r_wr_ptr;
    w_count_nxt = r_count;
    if (w_do_push && !w_do_pop) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else if (!w_do_push && w_do_pop) begin
      w_count_nxt = r_count - CNT_W'(1);
    end
    w_bypass    = w_do_push && (r_wr_ptr == w_rd_nxt);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      for (int i = 0; i < int'(WIDTH_ELEMS); i++) begin
        r_dout[i] <= '0;
      end
    end else begin
      r_wr_ptr <= w_wr_nxt;
      r_rd_ptr <= w_rd_nxt;
      r_count  <= w_count_nxt;
      r_full   <= (w_count_nxt == CNT_W'(DEPTH));
      r_empty  <= (w_count_nxt == '0);
      // Next head comes straight from din when it lands in the slot being exposed.
      for (int i = 0; i < int'(WIDTH_ELEMS); i++) begin
        r_dout[i] <= w_bypass ? din[i] : r_mem[w_rd_nxt][i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      for (int i = 0; i < int'(WIDTH_ELEMS); i++) begin
        r_mem[r_wr_ptr][i] <= din[i];
      end
    end
  end

  assign dout  = r_dout;
  assign full  = r_full;
  assign empty = r_empty;
  assign count = r_count;

endmodule

// File: rtl/array_drain.sv
// De-skews systolic-array columns into aligned rows and buffers them for writeback.
// Optional: define DRAIN_DROP_CNT_EN to add a saturating drop_count output.
module array_drain
  import tpu_pkg::*;
#(
  parameter int unsigned COLUMN_NUMBER = 256,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  input  elem_t                          down_in   [COLUMN_NUMBER],
  output logic                           out_valid,
  input  logic                           out_ready,
  output elem_t                          row_out   [COLUMN_NUMBER],
  output logic                           overflow,
  output logic [occ_w(FIFO_DEPTH)-1:0]   occupancy
`ifdef DRAIN_DROP_CNT_EN
  ,
  output logic [15:0]                    drop_count
`endif
);

  logic [COLUMN_NUMBER-1:0] w_vld;
  logic [COLUMN_NUMBER-2:0] r_vld;
  elem_t                    w_row [COLUMN_NUMBER];
  logic                     w_push;
  logic                     w_pop;
  logic                     w_full;
  logic                     w_empty;
  logic                     w_drop;
  logic                     r_overflow;

  // w_vld[c] is in_valid delayed c cycles: the cycle column c carries its element.
  assign w_vld = {r_vld, in_valid};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld <= '0;
    end else begin
      r_vld <= w_vld[COLUMN_NUMBER-2:0];
    end
  end

  for (genvar c = 0; c < COLUMN_NUMBER; c++) begin : g_col
    if (c < COLUMN_NUMBER - 1) begin : g_dly
      localparam int unsigned DLY = COLUMN_NUMBER - 1 - c;
      elem_t r_dly [DLY];

      // Each stage loads only when the element it would take is valid.
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int j = 0; j < int'(DLY); j++) begin
            r_dly[j] <= '0;
          end
        end else begin
          if (w_vld[c]) begin
            r_dly[0] <= down_in[c];
          end
          for (int j = 1; j < int'(DLY); j++) begin
            if (w_vld[c + j]) begin
              r_dly[j] <= r_dly[j-1];
            end
          end
        end
      end

      assign w_row[c] = r_dly[DLY-1];
    end else begin : g_pass
      assign w_row[c] = down_in[c];
    end
  end

  assign w_push = w_vld[COLUMN_NUMBER-1];
  assign w_pop  = !w_empty && out_ready;
  assign w_drop = w_push && w_full && !w_pop;

  drain_fifo #(
    .WIDTH_ELEMS (COLUMN_NUMBER),
    .DEPTH       (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_row),
    .dout  (row_out),
    .full  (w_full),
    .empty (w_empty),
    .count (occupancy)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end
  end

  assign out_valid = !w_empty;
  assign overflow  = r_overflow;

`ifdef DRAIN_DROP_CNT_EN
  logic [15:0] r_drop_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_drop_count <= '0;
    end else if (w_drop && (r_drop_count != 16'hFFFF)) begin
      r_drop_count <= r_drop_count + 16'd1;
    end
  end

  assign drop_count = r_drop_count;
`endif

endmodule

// File: tb/tb_array_drain.sv
// Directed bench for array_drain with COLUMN_NUMBER=4, FIFO_DEPTH=2.
module tb_array_drain;

  localparam int unsigned N = 4;
  localparam int unsigned D = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       out_ready;
  logic       out_valid;
  logic       overflow;
  logic [7:0] down_in [N];
  logic [7:0] row_out [N];
  logic [1:0] occupancy;
`ifdef DRAIN_DROP_CNT_EN
  logic [15:0] drop_count;
`endif

  array_drain #(
    .COLUMN_NUMBER (N),
    .FIFO_DEPTH    (D)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .down_in   (down_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .row_out   (row_out),
    .overflow  (overflow),
    .occupancy (occupancy)
`ifdef DRAIN_DROP_CNT_EN
    ,
    .drop_count (drop_count)
`endif
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic        hv [0:255];
  logic [7:0]  hb [0:255];
  logic        s_v;
  logic        s_ovf;
  logic [1:0]  s_occ;
  logic [31:0] s_row;
  logic [31:0] rx_q [$];
  int          rx_cyc [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive skewed inputs, sample mid-cycle, log accepted rows.
  task automatic step(input logic v, input logic [7:0] base, input logic rdy);
    in_valid  = v;
    out_ready = rdy;
    hv[cyc]   = v;
    hb[cyc]   = base;
    for (int c = 0; c < int'(N); c++) begin
      if ((cyc - c) >= 0 && hv[cyc - c]) down_in[c] = hb[cyc - c] + 8'(c);
      else                               down_in[c] = 8'hE0 + 8'(c);
    end
    #4;
    s_v   = out_valid;
    s_ovf = overflow;
    s_occ = occupancy;
    s_row = {row_out[0], row_out[1], row_out[2], row_out[3]};
    if (out_valid && out_ready) begin
      rx_q.push_back(s_row);
      rx_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      hv[i] = 1'b0;
      hb[i] = 8'h00;
    end
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    for (int c = 0; c < int'(N); c++) down_in[c] = 8'h00;
    @(posedge clk);
    #1;
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    reset = 1'b0;

    // Reset state
    step(1'b0, 8'h00, 1'b0);
    chk("rst_valid", 32'(s_v), 32'd0);
    chk("rst_row", s_row, 32'd0);
    chk("rst_ovf", 32'(s_ovf), 32'd0);
    chk("rst_occ", 32'(s_occ), 32'd0);

    // Single row latency
    step(1'b1, 8'h10, 1'b1);
    chk("t1_lat0", 32'(s_v), 32'd0);
    for (int i = 1; i < 4; i++) begin
      step(1'b0, 8'h00, 1'b1);
      chk("t1_early", 32'(s_v), 32'd0);
    end
    step(1'b0, 8'h00, 1'b1);
    chk("t1_valid", 32'(s_v), 32'd1);
    chk("t1_row", s_row, 32'h10111213);
    step(1'b0, 8'h00, 1'b1);
    chk("t1_after_pop", 32'(s_v), 32'd0);

    // Streaming at full rate
    rx_q.delete();
    rx_cyc.delete();
    for (int r = 0; r < 8; r++) step(1'b1, 8'(16 * r), 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b1);
    chk("t2_count", 32'(rx_q.size()), 32'd8);
    for (int r = 0; r < 8; r++)
      chk("t2_row", rx_q[r], {8'(16 * r), 8'(16 * r + 1), 8'(16 * r + 2), 8'(16 * r + 3)});
    chk("t2_span", 32'(rx_cyc[7] - rx_cyc[0]), 32'd7);
    chk("t2_ovf", 32'(s_ovf), 32'd0);

    // Full FIFO with simultaneous pop and push
    rx_q.delete();
    step(1'b1, 8'h20, 1'b0);
    step(1'b1, 8'h30, 1'b0);
    step(1'b1, 8'hA0, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    chk("t4_full_occ", 32'(s_occ), 32'd2);
    chk("t4_full_row", s_row, 32'h20212223);
    step(1'b0, 8'h00, 1'b0);
    chk("t4_occ_hold", 32'(s_occ), 32'd2);
    chk("t4_head", s_row, 32'h30313233);
    chk("t4_ovf", 32'(s_ovf), 32'd0);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);
    chk("t4_count", 32'(rx_q.size()), 32'd3);
    chk("t4_row0", rx_q[0], 32'h20212223);
    chk("t4_row1", rx_q[1], 32'h30313233);
    chk("t4_row2", rx_q[2], 32'hA0A1A2A3);
    chk("t4_occ_end", 32'(s_occ), 32'd0);

    // Gaps in in_valid
    rx_q.delete();
    step(1'b1, 8'h80, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h90, 1'b1);
    step(1'b1, 8'hA0, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'hB0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b1);
    chk("t6_count", 32'(rx_q.size()), 32'd4);
    chk("t6_row0", rx_q[0], 32'h80818283);
    chk("t6_row1", rx_q[1], 32'h90919293);
    chk("t6_row2", rx_q[2], 32'hA0A1A2A3);
    chk("t6_row3", rx_q[3], 32'hB0B1B2B3);
    chk("t6_ovf", 32'(s_ovf), 32'd0);

    // Backpressure and drop
    rx_q.delete();
    step(1'b1, 8'h40, 1'b0);
    step(1'b1, 8'h50, 1'b0);
    step(1'b1, 8'h60, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("t3_ovf_before", 32'(s_ovf), 32'd0);
    step(1'b0, 8'h00, 1'b0);
    chk("t3_ovf", 32'(s_ovf), 32'd1);
    chk("t3_occ", 32'(s_occ), 32'd2);
    chk("t3_valid", 32'(s_v), 32'd1);
    chk("t3_head", s_row, 32'h40414243);
`ifdef DRAIN_DROP_CNT_EN
    chk("t3_drop_count", 32'(drop_count), 32'd1);
`endif
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);
    chk("t3_count", 32'(rx_q.size()), 32'd2);
    chk("t3_row0", rx_q[0], 32'h40414243);
    chk("t3_row1", rx_q[1], 32'h50515253);
    chk("t3_sticky", 32'(s_ovf), 32'd1);
    chk("t3_occ_end", 32'(s_occ), 32'd0);

    // Reset while a row is in flight
    step(1'b1, 8'hC0, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    reset = 1'b1;
    step(1'b0, 8'h00, 1'b1);
    reset = 1'b0;
    for (int i = 0; i < int'(N) + 2; i++) begin
      step(1'b0, 8'h00, 1'b1);
      chk("t5_quiet", 32'(s_v), 32'd0);
    end
    chk("t5_ovf", 32'(s_ovf), 32'd0);
    chk("t5_occ", 32'(s_occ), 32'd0);
`ifdef DRAIN_DROP_CNT_EN
    chk("t5_drop_count", 32'(drop_count), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
